// File: rtl/rom_load_seq_if.sv
// ioctl download stream from the HPS: one byte per ioctl_wr pulse while ioctl_download is high.
interface rom_load_seq_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/rom_load_seq.sv
// Download sequencer: splits the ioctl byte stream into four ROM regions, tracks
// load statistics, and holds the core in reset until a load has settled.
module rom_load_seq #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] R1_BASE    = 16'h6000,
  parameter logic [ADDR_W-1:0] R2_BASE    = 16'h8000,
  parameter logic [ADDR_W-1:0] R3_BASE    = 16'hA000,
  parameter logic [ADDR_W:0]   ROM_SIZE   = 17'h0C000,
  parameter int                SETTLE_CYC = 255
) (
  input  logic              clk_sys,
  input  logic              RESET,
  rom_load_seq_if.slave     ioctl,
  input  logic              user_reset,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic [3:0]        dn_wr,
  output logic              core_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  output logic              oor_flag
);

  localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

  state_t             state_q, next_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  addr_lo_p0;
  logic               in_range_p0;
  logic               acc_vld_p0;
  logic               wr_vld_p0;
  logic [1:0]         region_p0;
  logic [ADDR_W-1:0]  ofs_p0;
  logic [3:0]         wr_oh_p0;
  logic               load_entry;
  logic               load_exit;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + (ADDR_W+1)'(1);
  endfunction

  // Stage p0: decode the byte presented on this edge
  always_comb begin
    addr_lo_p0  = ioctl.ioctl_addr[ADDR_W-1:0];
    in_range_p0 = (ioctl.ioctl_addr[24:ADDR_W] == '0) && ({1'b0, addr_lo_p0} < ROM_SIZE);
    acc_vld_p0  = ioctl.ioctl_download & ioctl.ioctl_wr;
    wr_vld_p0   = acc_vld_p0 & in_range_p0;
    region_p0   = 2'd0;
    ofs_p0      = addr_lo_p0;
    if (addr_lo_p0 >= R3_BASE) begin
      region_p0 = 2'd3;
      ofs_p0    = addr_lo_p0 - R3_BASE;
    end else if (addr_lo_p0 >= R2_BASE) begin
      region_p0 = 2'd2;
      ofs_p0    = addr_lo_p0 - R2_BASE;
    end else if (addr_lo_p0 >= R1_BASE) begin
      region_p0 = 2'd1;
      ofs_p0    = addr_lo_p0 - R1_BASE;
    end
    wr_oh_p0 = wr_vld_p0 ? (4'b0001 << region_p0) : 4'b0000;
  end

  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ioctl.ioctl_download) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (!ioctl.ioctl_download) begin
          next_state = S_SETTLE;
          cnt_d      = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (ioctl.ioctl_download) next_state = S_LOAD;
        else if (user_reset)      cnt_d = SETTLE_LD;
        else if (cnt_q == '0)     next_state = S_RUN;
        else                      cnt_d = cnt_q - 1'b1;
      end
      S_RUN: begin
        if (ioctl.ioctl_download) next_state = S_LOAD;
        else if (user_reset) begin
          next_state = S_SETTLE;
          cnt_d      = SETTLE_LD;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign load_entry = ioctl.ioctl_download && (state_q != S_LOAD);
  assign load_exit  = (state_q == S_LOAD) && (next_state == S_SETTLE);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state_q    <= next_state;
      cnt_q      <= cnt_d;
      core_reset <= (next_state != S_RUN);
      load_done  <= load_done | load_exit;
    end
  end

  // Stage p1: registered strobe and running statistics; the entry edge byte seeds the stats
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      dn_wr      <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      byte_count <= '0;
      checksum   <= '0;
      oor_flag   <= 1'b0;
    end else begin
      dn_wr <= wr_oh_p0;
      if (wr_vld_p0) begin
        dn_addr <= ofs_p0;
        dn_data <= ioctl.ioctl_dout;
      end
      if (load_entry) begin
        byte_count <= wr_vld_p0 ? (ADDR_W+1)'(1) : '0;
        checksum   <= wr_vld_p0 ? ioctl.ioctl_dout : 8'h00;
        oor_flag   <= acc_vld_p0 & ~in_range_p0;
      end else begin
        if (wr_vld_p0) begin
          byte_count <= sat_inc(byte_count);
          checksum   <= checksum + ioctl.ioctl_dout;
        end
        if (acc_vld_p0 && !in_range_p0) oor_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_load_seq.sv
// Directed bench for rom_load_seq: a 16-bit instance for decode/timing and an
// 8-bit instance sharing the same stream to reach byte_count saturation quickly.
module tb_rom_load_seq;
  logic clk_sys = 1'b0;
  logic RESET;
  logic user_reset;

  rom_load_seq_if ioctl_bus();

  logic [15:0] b_dn_addr;
  logic [7:0]  b_dn_data;
  logic [3:0]  b_dn_wr;
  logic        b_core_reset, b_load_done, b_oor_flag;
  logic [16:0] b_byte_count;
  logic [7:0]  b_checksum;

  logic [7:0]  s_dn_addr;
  logic [7:0]  s_dn_data;
  logic [3:0]  s_dn_wr;
  logic        s_core_reset, s_load_done, s_oor_flag;
  logic [8:0]  s_byte_count;
  logic [7:0]  s_checksum;

  rom_load_seq #(
    .ADDR_W(16), .R1_BASE(16'h6000), .R2_BASE(16'h8000), .R3_BASE(16'hA000),
    .ROM_SIZE(17'h0C000), .SETTLE_CYC(4)
  ) u_big (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl(ioctl_bus), .user_reset(user_reset),
    .dn_addr(b_dn_addr), .dn_data(b_dn_data), .dn_wr(b_dn_wr), .core_reset(b_core_reset),
    .load_done(b_load_done), .byte_count(b_byte_count), .checksum(b_checksum),
    .oor_flag(b_oor_flag)
  );

  rom_load_seq #(
    .ADDR_W(8), .R1_BASE(8'h60), .R2_BASE(8'h80), .R3_BASE(8'hA0),
    .ROM_SIZE(9'h0C0), .SETTLE_CYC(4)
  ) u_small (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl(ioctl_bus), .user_reset(user_reset),
    .dn_addr(s_dn_addr), .dn_data(s_dn_data), .dn_wr(s_dn_wr), .core_reset(s_core_reset),
    .load_done(s_load_done), .byte_count(s_byte_count), .checksum(s_checksum),
    .oor_flag(s_oor_flag)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  din;
    logic        ur;
    logic [3:0]  e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic [16:0] e_cnt;
    logic [7:0]  e_sum;
    logic        e_oor;
    logic        e_cr;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic dl, input logic wr, input logic [24:0] addr,
                              input logic [7:0] din, input logic ur, input logic [3:0] e_wr,
                              input logic [15:0] e_addr, input logic [7:0] e_data,
                              input logic [16:0] e_cnt, input logic [7:0] e_sum,
                              input logic e_oor, input logic e_cr, input logic e_done);
    vec_t v;
    v.dl = dl; v.wr = wr; v.addr = addr; v.din = din; v.ur = ur;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data; v.e_cnt = e_cnt;
    v.e_sum = e_sum; v.e_oor = e_oor; v.e_cr = e_cr; v.e_done = e_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dl, input logic wr, input logic [24:0] a,
                       input logic [7:0] d, input logic ur);
    ioctl_bus.ioctl_download = dl;
    ioctl_bus.ioctl_wr       = wr;
    ioctl_bus.ioctl_addr     = a;
    ioctl_bus.ioctl_dout     = d;
    user_reset               = ur;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);

    // Region decode, out-of-range, trailing write
    tbl.push_back(mk(1,1,25'h00000,8'h11,0, 4'b0001,16'h0000,8'h11,17'd1,8'h11,0,1,0));
    tbl.push_back(mk(1,1,25'h05FFF,8'h22,0, 4'b0001,16'h5FFF,8'h22,17'd2,8'h33,0,1,0));
    tbl.push_back(mk(1,1,25'h06000,8'h33,0, 4'b0010,16'h0000,8'h33,17'd3,8'h66,0,1,0));
    tbl.push_back(mk(1,1,25'h0A001,8'h44,0, 4'b1000,16'h0001,8'h44,17'd4,8'hAA,0,1,0));
    tbl.push_back(mk(1,0,25'h0A001,8'h99,0, 4'b0000,16'h0001,8'h44,17'd4,8'hAA,0,1,0));
    tbl.push_back(mk(1,1,25'h08005,8'h10,0, 4'b0100,16'h0005,8'h10,17'd5,8'hBA,0,1,0));
    tbl.push_back(mk(1,1,25'h0C000,8'h55,0, 4'b0000,16'h0005,8'h10,17'd5,8'hBA,1,1,0));
    tbl.push_back(mk(1,1,25'h10000,8'h66,0, 4'b0000,16'h0005,8'h10,17'd5,8'hBA,1,1,0));
    tbl.push_back(mk(1,1,25'h09FFF,8'h01,0, 4'b0100,16'h1FFF,8'h01,17'd6,8'hBB,1,1,0));
    // Release: download low at e0, core_reset high through e4, low from e5
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,0,1));
    // 3-cycle user_reset in RUN
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,1, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,0,1));
    // user_reset pulse again, then a second pulse inside SETTLE reloads the count
    tbl.push_back(mk(0,0,25'h0,8'h0,1, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    tbl.push_back(mk(0,0,25'h0,8'h0,1, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,1,1));
    tbl.push_back(mk(0,0,25'h0,8'h0,0, 4'b0000,16'h1FFF,8'h01,17'd6,8'hBB,1,0,1));
    // New download from RUN: stats restart with the entry-edge byte, oor cleared
    tbl.push_back(mk(1,1,25'h00002,8'h05,0, 4'b0001,16'h0002,8'h05,17'd1,8'h05,0,1,1));
    tbl.push_back(mk(1,0,25'h00000,8'h00,0, 4'b0000,16'h0002,8'h05,17'd1,8'h05,0,1,1));

    repeat (3) tick();
    check("rst dn_wr",      {28'h0, b_dn_wr}, 32'h0);
    check("rst dn_addr",    {16'h0, b_dn_addr}, 32'h0);
    check("rst dn_data",    {24'h0, b_dn_data}, 32'h0);
    check("rst core_reset", {31'h0, b_core_reset}, 32'h1);
    check("rst load_done",  {31'h0, b_load_done}, 32'h0);
    check("rst byte_count", {15'h0, b_byte_count}, 32'h0);
    check("rst checksum",   {24'h0, b_checksum}, 32'h0);
    check("rst oor_flag",   {31'h0, b_oor_flag}, 32'h0);

    #3 RESET = 1'b0;
    repeat (3) tick();
    check("idle core_reset", {31'h0, b_core_reset}, 32'h1);

    foreach (tbl[i]) begin
      drive(tbl[i].dl, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].ur);
      tick();
      check($sformatf("row%0d dn_wr", i),      {28'h0, b_dn_wr}, {28'h0, tbl[i].e_wr});
      check($sformatf("row%0d dn_addr", i),    {16'h0, b_dn_addr}, {16'h0, tbl[i].e_addr});
      check($sformatf("row%0d dn_data", i),    {24'h0, b_dn_data}, {24'h0, tbl[i].e_data});
      check($sformatf("row%0d byte_count", i), {15'h0, b_byte_count}, {15'h0, tbl[i].e_cnt});
      check($sformatf("row%0d checksum", i),   {24'h0, b_checksum}, {24'h0, tbl[i].e_sum});
      check($sformatf("row%0d oor_flag", i),   {31'h0, b_oor_flag}, {31'h0, tbl[i].e_oor});
      check($sformatf("row%0d core_reset", i), {31'h0, b_core_reset}, {31'h0, tbl[i].e_cr});
      check($sformatf("row%0d load_done", i),  {31'h0, b_load_done}, {31'h0, tbl[i].e_done});
    end

    // Asynchronous RESET between edges while a strobe is active
    drive(1'b1, 1'b1, 25'h06001, 8'h77, 1'b0);
    tick();
    check("pre-async dn_wr", {28'h0, b_dn_wr}, 32'h2);
    #2 RESET = 1'b1;
    #1;
    check("async core_reset", {31'h0, b_core_reset}, 32'h1);
    check("async dn_wr",      {28'h0, b_dn_wr}, 32'h0);
    check("async load_done",  {31'h0, b_load_done}, 32'h0);
    check("async byte_count", {15'h0, b_byte_count}, 32'h0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #1 RESET = 1'b0;
    repeat (8) tick();
    check("post-async idle core_reset", {31'h0, b_core_reset}, 32'h1);
    check("post-async load_done",       {31'h0, b_load_done}, 32'h0);

    // 520 bytes: the 9-bit counter of the small instance pins at 0x1FF
    drive(1'b1, 1'b1, 25'h00010, 8'h01, 1'b0);
    repeat (520) tick();
    check("sat small byte_count", {23'h0, s_byte_count}, 32'h1FF);
    check("sat big byte_count",   {15'h0, b_byte_count}, 32'd520);
    check("sat small checksum",   {24'h0, s_checksum}, 32'h08);
    check("sat big checksum",     {24'h0, b_checksum}, 32'h08);
    check("sat small dn_wr",      {28'h0, s_dn_wr}, 32'h1);
    check("sat small dn_addr",    {24'h0, s_dn_addr}, 32'h10);
    check("sat small dn_data",    {24'h0, s_dn_data}, 32'h01);
    check("sat small oor_flag",   {31'h0, s_oor_flag}, 32'h0);
    check("sat small core_reset", {31'h0, s_core_reset}, 32'h1);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    check("sat small held count", {23'h0, s_byte_count}, 32'h1FF);
    check("sat small load_done",  {31'h0, s_load_done}, 32'h1);
    check("sat big load_done",    {31'h0, b_load_done}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
